// File: rtl/arm7tdmi_tap_controller.sv
// IEEE 1149.1 TAP controller for the ARM7TDMI: 16-state FSM, 4-bit IR, ID, bypass and
// boundary-scan control strobes. TDO/TDO-enable launch on the falling edge of tck.
module arm7tdmi_tap_controller #(
    parameter logic [31:0] IDCODE_VAL = 32'h3F0F0F0F,
    parameter int unsigned IR_WIDTH   = 4
) (
    input  logic                tck,
    input  logic                trst,
    input  logic                tms,
    input  logic                tdi,
    output logic                tdo,
    output logic                tdo_en,
    input  logic                bscan_tdo,
    output logic                bscan_select,
    output logic                capture_dr,
    output logic                shift_dr,
    output logic                update_dr,
    output logic                extest_mode,
    output logic                sample_mode,
    output logic [3:0]          tap_state,
    output logic [IR_WIDTH-1:0] ir_out
);

    typedef enum logic [3:0] {
        StTlr   = 4'hF, StRti   = 4'hC, StSelDr = 4'h7, StCapDr = 4'h6,
        StShDr  = 4'h2, StEx1Dr = 4'h1, StPauDr = 4'h3, StEx2Dr = 4'h0,
        StUpdDr = 4'h5, StSelIr = 4'h4, StCapIr = 4'hE, StShIr  = 4'hA,
        StEx1Ir = 4'h9, StPauIr = 4'hB, StEx2Ir = 4'h8, StUpdIr = 4'hD
    } tap_state_e;

    localparam logic [IR_WIDTH-1:0] IrExtest  = 4'b0000;
    localparam logic [IR_WIDTH-1:0] IrSample  = 4'b0011;
    localparam logic [IR_WIDTH-1:0] IrIdcode  = 4'b1110;
    localparam logic [IR_WIDTH-1:0] IrCapture = 4'b0001;

    tap_state_e          state_q, state_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
    logic [31:0]         id_q, id_d;
    logic                bypass_q, bypass_d;
    logic                tdo_q, tdo_d;
    logic                tdo_en_q, tdo_en_d;
    logic                idcode_sel, bypass_sel;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StTlr:   state_d = tms ? StTlr   : StRti;
            StRti:   state_d = tms ? StSelDr : StRti;
            StSelDr: state_d = tms ? StSelIr : StCapDr;
            StCapDr: state_d = tms ? StEx1Dr : StShDr;
            StShDr:  state_d = tms ? StEx1Dr : StShDr;
            StEx1Dr: state_d = tms ? StUpdDr : StPauDr;
            StPauDr: state_d = tms ? StEx2Dr : StPauDr;
            StEx2Dr: state_d = tms ? StUpdDr : StShDr;
            StUpdDr: state_d = tms ? StSelDr : StRti;
            StSelIr: state_d = tms ? StTlr   : StCapIr;
            StCapIr: state_d = tms ? StEx1Ir : StShIr;
            StShIr:  state_d = tms ? StEx1Ir : StShIr;
            StEx1Ir: state_d = tms ? StUpdIr : StPauIr;
            StPauIr: state_d = tms ? StEx2Ir : StPauIr;
            StEx2Ir: state_d = tms ? StUpdIr : StShIr;
            StUpdIr: state_d = tms ? StSelDr : StRti;
            default: state_d = StTlr;
        endcase
    end

    // Instruction decode; unrecognised codes fall through to the bypass register.
    assign extest_mode  = (ir_q == IrExtest);
    assign sample_mode  = (ir_q == IrSample);
    assign idcode_sel   = (ir_q == IrIdcode);
    assign bscan_select = extest_mode | sample_mode;
    assign bypass_sel   = ~(bscan_select | idcode_sel);

    assign capture_dr = (state_q == StCapDr);
    assign shift_dr   = (state_q == StShDr);
    assign update_dr  = (state_q == StUpdDr);

    always_comb begin
        ir_d     = ir_q;
        ir_sr_d  = ir_sr_q;
        id_d     = id_q;
        bypass_d = bypass_q;
        case (state_q)
            StTlr:   ir_d    = IrIdcode;
            StCapIr: ir_sr_d = IrCapture;
            StShIr:  ir_sr_d = {tdi, ir_sr_q[IR_WIDTH-1:1]};
            StUpdIr: ir_d    = ir_sr_q;
            StCapDr: begin
                if (idcode_sel) id_d     = IDCODE_VAL;
                if (bypass_sel) bypass_d = 1'b0;
            end
            StShDr: begin
                if (idcode_sel) id_d     = {tdi, id_q[31:1]};
                if (bypass_sel) bypass_d = tdi;
            end
            default: ;
        endcase
    end

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            state_q  <= StTlr;
            ir_q     <= IrIdcode;
            ir_sr_q  <= IrCapture;
            id_q     <= IDCODE_VAL;
            bypass_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            ir_sr_q  <= ir_sr_d;
            id_q     <= id_d;
            bypass_q <= bypass_d;
        end
    end

    always_comb begin
        tdo_d    = tdo_q;
        tdo_en_d = (state_q == StShIr) || (state_q == StShDr);
        if (state_q == StShIr) begin
            tdo_d = ir_sr_q[0];
        end else if (state_q == StShDr) begin
            if (bscan_select)    tdo_d = bscan_tdo;
            else if (idcode_sel) tdo_d = id_q[0];
            else                 tdo_d = bypass_q;
        end
    end

    always_ff @(negedge tck or posedge trst) begin
        if (trst) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_d;
            tdo_en_q <= tdo_en_d;
        end
    end

    assign tdo       = tdo_q;
    assign tdo_en    = tdo_en_q;
    assign tap_state = state_q;
    assign ir_out    = ir_q;

endmodule

// File: tb/tb_arm7tdmi_tap_controller.sv
// Directed bench for arm7tdmi_tap_controller: reset, IDCODE read, EXTEST/SAMPLE/BYPASS
// instructions, boundary-scan strobes, mid-shift reset abort and Pause-DR resume.
module tb_arm7tdmi_tap_controller;

    logic       tck = 1'b0;
    logic       trst, tms, tdi, bscan_tdo;
    logic       tdo, tdo_en, bscan_select, capture_dr, shift_dr, update_dr;
    logic       extest_mode, sample_mode;
    logic [3:0] tap_state, ir_out;

    int n_cmp = 0;
    int n_err = 0;
    int cnt_cap, cnt_sh, cnt_upd;

    arm7tdmi_tap_controller #(
        .IDCODE_VAL (32'h3F0F0F0F),
        .IR_WIDTH   (4)
    ) dut (
        .tck          (tck),
        .trst         (trst),
        .tms          (tms),
        .tdi          (tdi),
        .tdo          (tdo),
        .tdo_en       (tdo_en),
        .bscan_tdo    (bscan_tdo),
        .bscan_select (bscan_select),
        .capture_dr   (capture_dr),
        .shift_dr     (shift_dr),
        .update_dr    (update_dr),
        .extest_mode  (extest_mode),
        .sample_mode  (sample_mode),
        .tap_state    (tap_state),
        .ir_out       (ir_out)
    );

    always #5 tck = ~tck;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge and tally the DR strobes seen there.
    task automatic tick();
        @(posedge tck);
        #1;
        if (capture_dr) cnt_cap++;
        if (shift_dr)   cnt_sh++;
        if (update_dr)  cnt_upd++;
    endtask

    // One tck: drive tms/tdi, sample tdo/tdo_en after the falling edge, then clock.
    task automatic cyc(input logic m, input logic d, output logic o, output logic en);
        tms = m;
        tdi = d;
        @(negedge tck);
        #1;
        o  = tdo;
        en = tdo_en;
        tick();
    endtask

    task automatic step(input logic m);
        logic o, en;
        cyc(m, 1'b0, o, en);
    endtask

    // From RTI: load a 4-bit instruction, return the captured IR bits, end in RTI.
    task automatic shift_ir(input logic [3:0] v, output logic [3:0] cap);
        logic o, en;
        step(1'b1); step(1'b1); step(1'b0); step(1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(i == 3, v[i], o, en);
            cap[i] = o;
        end
        step(1'b1); step(1'b0);
    endtask

    // From RTI: 4-bit DR scan, end in RTI.
    task automatic scan_dr4(input logic [3:0] d, output logic [3:0] q);
        logic o, en;
        step(1'b1); step(1'b0); step(1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(i == 3, d[i], o, en);
            q[i] = o;
        end
        step(1'b1); step(1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] word;
        logic [3:0]  cap, q;
        logic        o, en;

        trst = 1'b1; tms = 1'b1; tdi = 1'b0; bscan_tdo = 1'b0;
        cnt_cap = 0; cnt_sh = 0; cnt_upd = 0;
        repeat (2) @(posedge tck);
        #1;
        check_eq("rst_state", 32'(tap_state), 32'hF);
        check_eq("rst_ir", 32'(ir_out), 32'hE);
        check_eq("rst_tdo", 32'({tdo, tdo_en}), 32'h0);
        check_eq("rst_strobes", 32'({bscan_select, capture_dr, shift_dr, update_dr,
                                     extest_mode, sample_mode}), 32'h0);
        trst = 1'b0;
        step(1'b1);
        check_eq("tlr_hold", 32'(tap_state), 32'hF);

        // IDCODE read
        step(1'b0); check_eq("to_rti", 32'(tap_state), 32'hC);
        step(1'b1); check_eq("to_seldr", 32'(tap_state), 32'h7);
        step(1'b0); check_eq("capdr_strobe", 32'({tap_state, capture_dr}), 32'hD);
        step(1'b0); check_eq("to_shdr", 32'(tap_state), 32'h2);
        for (int i = 0; i < 32; i++) begin
            cyc(i == 31, 1'b0, o, en);
            word[i] = o;
            if (i == 0) check_eq("shdr_tdo_en", 32'(en), 32'h1);
        end
        check_eq("idcode_word", word, 32'h3F0F0F0F);
        check_eq("to_ex1dr", 32'(tap_state), 32'h1);
        step(1'b1); check_eq("upddr_strobe", 32'({tap_state, update_dr}), 32'hB);
        step(1'b0);

        // EXTEST
        shift_ir(4'b0000, cap);
        check_eq("extest_ir_capture", 32'(cap), 32'h1);
        check_eq("extest_ir_out", 32'(ir_out), 32'h0);
        check_eq("extest_modes", 32'({extest_mode, bscan_select, sample_mode}), 32'h6);

        // Boundary-scan path with EXTEST active
        cnt_cap = 0; cnt_sh = 0; cnt_upd = 0;
        step(1'b1); step(1'b0); step(1'b0);
        for (int i = 0; i < 4; i++) begin
            bscan_tdo = (4'b1101 >> i) & 4'b0001 ? 1'b1 : 1'b0;
            cyc(i == 3, 1'b0, o, en);
            q[i] = o;
        end
        bscan_tdo = 1'b0;
        step(1'b1); step(1'b0);
        check_eq("bscan_tdo_path", 32'(q), 32'hD);
        check_eq("bscan_cap_cnt", 32'(cnt_cap), 32'd1);
        check_eq("bscan_shift_cnt", 32'(cnt_sh), 32'd4);
        check_eq("bscan_upd_cnt", 32'(cnt_upd), 32'd1);
        check_eq("bscan_ir_kept", 32'(ir_out), 32'h0);

        // SAMPLE
        shift_ir(4'b0011, cap);
        check_eq("sample_modes", 32'({extest_mode, bscan_select, sample_mode}), 32'h3);

        // BYPASS and an unknown code
        shift_ir(4'b1111, cap);
        check_eq("bypass_ir_out", 32'(ir_out), 32'hF);
        check_eq("bypass_bsel", 32'(bscan_select), 32'h0);
        scan_dr4(4'b1101, q);
        check_eq("bypass_tdo", 32'(q), 32'hA);
        shift_ir(4'b0101, cap);
        check_eq("unknown_ir_out", 32'(ir_out), 32'h5);
        scan_dr4(4'b1101, q);
        check_eq("unknown_tdo", 32'(q), 32'hA);

        // Reset asserted mid-shift
        step(1'b1); step(1'b0); step(1'b0);
        check_eq("pre_abort_shdr", 32'(tap_state), 32'h2);
        cyc(1'b0, 1'b1, o, en);
        cnt_upd = 0;
        trst = 1'b1;
        #2;
        check_eq("abort_state", 32'(tap_state), 32'hF);
        check_eq("abort_ir", 32'(ir_out), 32'hE);
        check_eq("abort_tdo_en", 32'(tdo_en), 32'h0);
        check_eq("abort_strobes", 32'({bscan_select, capture_dr, shift_dr, update_dr,
                                       extest_mode, sample_mode}), 32'h0);
        tms = 1'b0;
        tick();
        check_eq("abort_hold", 32'(tap_state), 32'hF);
        trst = 1'b0;
        step(1'b0); check_eq("abort_to_rti", 32'(tap_state), 32'hC);
        repeat (5) step(1'b1);
        check_eq("five_tms_tlr", 32'(tap_state), 32'hF);
        check_eq("abort_no_update", 32'(cnt_upd), 32'd0);

        // Pause-DR midway through an IDCODE shift
        step(1'b0); step(1'b1); step(1'b0); step(1'b0);
        word = '0;
        for (int i = 0; i < 16; i++) begin
            cyc(i == 15, 1'b0, o, en);
            word[i] = o;
        end
        step(1'b0);
        check_eq("to_paudr", 32'(tap_state), 32'h3);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, o, en);
            if (i == 0) check_eq("pause_tdo_en", 32'(en), 32'h0);
        end
        check_eq("paudr_hold", 32'(tap_state), 32'h3);
        step(1'b1); check_eq("to_ex2dr", 32'(tap_state), 32'h0);
        step(1'b0);
        for (int i = 16; i < 32; i++) begin
            cyc(i == 31, 1'b0, o, en);
            word[i] = o;
        end
        check_eq("pause_idcode_word", word, 32'h3F0F0F0F);
        step(1'b1); step(1'b0);
        check_eq("final_rti", 32'(tap_state), 32'hC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
